// File: rtl/pd_seq_checker.sv
// pd_seq_checker: issues signed operand/pattern vectors to an external
// multiplier + pattern-detect block, predicts the product and detect flag for
// each vector, and checks the returns after P_LAT / D_LAT cycles. Counts
// detects seen and per-vector mismatches over a run of count_i vectors.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both 1. cmd_ready_o depends only on registered state, so
// it never combinationally depends on cmd_valid_i. The source holds its
// command stable while valid is high and ready is low.
//
// P_LAT must not exceed D_LAT: the product check result is carried along
// the delay line and merged with the detect check into one error per vector.
module pd_seq_checker #(
  parameter int width_in1 = 26,
  parameter int width_in2 = 14,
  parameter int width_out = 40,
  parameter logic [width_out:0] MASK = '0,
  parameter int P_LAT = 2,
  parameter int D_LAT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [7:0]           count_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [width_in1:0]   cmd_a_i,
  input  logic [width_in2:0]   cmd_b_i,
  input  logic [width_out:0]   cmd_pat_i,
  output logic [width_in1:0]   pd_a_o,
  output logic [width_in2:0]   pd_b_o,
  output logic [width_out:0]   pd_pat_o,
  input  logic [width_out:0]   pd_c_i,
  input  logic                 pd_ones_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           match_cnt_o,
  output logic [7:0]           err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] issued_q, issued_d;
  logic [7:0] match_q, match_d;
  logic [7:0] err_q, err_d;
  logic [width_in1:0] pd_a_q, pd_a_d;
  logic [width_in2:0] pd_b_q, pd_b_d;
  logic [width_out:0] pd_pat_q, pd_pat_d;

  // Delay line: slot k holds the vector driven k cycles ago. Product
  // expectations are only needed up to the product return slot.
  logic               dl_v_q  [0:D_LAT];
  logic               dl_v_d  [0:D_LAT];
  logic               dl_e_q  [0:D_LAT];
  logic               dl_e_d  [0:D_LAT];
  logic               dl_pm_q [0:D_LAT];
  logic               dl_pm_d [0:D_LAT];
  logic [width_out:0] dl_c_q  [0:P_LAT];
  logic [width_out:0] dl_c_d  [0:P_LAT];

  logic                      xfer;
  logic signed [width_out:0] a_ext;
  logic signed [width_out:0] b_ext;
  logic [width_out:0]        exp_c;
  logic                      exp_d;
  logic                      prod_mis;
  logic                      det_mis;
  logic                      pm_at_d;
  logic                      vec_match;
  logic                      vec_err;
  logic                      pending;

  assign cmd_ready_o = (state_q == S_RUN) && (issued_q < count_q);
  assign xfer        = cmd_valid_i & cmd_ready_o;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign match_cnt_o = match_q;
  assign err_cnt_o   = err_q;
  assign pd_a_o      = pd_a_q;
  assign pd_b_o      = pd_b_q;
  assign pd_pat_o    = pd_pat_q;

  // Expected product (truncated signed product) and detect for the incoming command.
  always_comb begin
    a_ext = (width_out + 1)'($signed(cmd_a_i));
    b_ext = (width_out + 1)'($signed(cmd_b_i));
    exp_c = a_ext * b_ext;
    exp_d = (exp_c == (cmd_pat_i | MASK));
  end

  // Compare returns against the slots that are due this cycle.
  always_comb begin
    prod_mis  = dl_v_q[P_LAT] && (pd_c_i != dl_c_q[P_LAT]);
    det_mis   = (pd_ones_i != dl_e_q[D_LAT]);
    pm_at_d   = (P_LAT == D_LAT) ? prod_mis : dl_pm_q[D_LAT];
    vec_match = dl_v_q[D_LAT] & pd_ones_i;
    vec_err   = dl_v_q[D_LAT] & (det_mis | pm_at_d);
    pending   = 1'b0;
    for (int i = 0; i < D_LAT; i++) begin
      pending = pending | dl_v_q[i];
    end
  end

  // Next-state logic: FSM, counters, operand registers and delay line.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    issued_d = issued_q;
    match_d  = match_q;
    err_d    = err_q;
    pd_a_d   = pd_a_q;
    pd_b_d   = pd_b_q;
    pd_pat_d = pd_pat_q;

    if (xfer) begin
      pd_a_d   = cmd_a_i;
      pd_b_d   = cmd_b_i;
      pd_pat_d = cmd_pat_i;
    end

    for (int i = 0; i <= D_LAT; i++) begin
      if (i == 0) begin
        dl_v_d[i]  = xfer;
        dl_e_d[i]  = exp_d;
        dl_pm_d[i] = 1'b0;
      end else begin
        dl_v_d[i]  = dl_v_q[i-1];
        dl_e_d[i]  = dl_e_q[i-1];
        dl_pm_d[i] = (i - 1 == P_LAT) ? prod_mis : dl_pm_q[i-1];
      end
    end
    for (int i = 0; i <= P_LAT; i++) begin
      if (i == 0) dl_c_d[i] = exp_c;
      else        dl_c_d[i] = dl_c_q[i-1];
    end

    if (vec_match && (match_q != 8'hFF)) match_d = match_q + 8'd1;
    if (vec_err && (err_q != 8'hFF))     err_d   = err_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (count_i != 8'd0) begin
            state_d  = S_RUN;
            count_d  = count_i;
            issued_d = 8'd0;
            match_d  = 8'd0;
            err_d    = 8'd0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          issued_d = issued_q + 8'd1;
          if (issued_q + 8'd1 == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pending) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      count_q  <= 8'd0;
      issued_q <= 8'd0;
      match_q  <= 8'd0;
      err_q    <= 8'd0;
      pd_a_q   <= '0;
      pd_b_q   <= '0;
      pd_pat_q <= '0;
      for (int i = 0; i <= D_LAT; i++) begin
        dl_v_q[i]  <= 1'b0;
        dl_e_q[i]  <= 1'b0;
        dl_pm_q[i] <= 1'b0;
      end
      for (int i = 0; i <= P_LAT; i++) begin
        dl_c_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      match_q  <= match_d;
      err_q    <= err_d;
      pd_a_q   <= pd_a_d;
      pd_b_q   <= pd_b_d;
      pd_pat_q <= pd_pat_d;
      for (int i = 0; i <= D_LAT; i++) begin
        dl_v_q[i]  <= dl_v_d[i];
        dl_e_q[i]  <= dl_e_d[i];
        dl_pm_q[i] <= dl_pm_d[i];
      end
      for (int i = 0; i <= P_LAT; i++) begin
        dl_c_q[i] <= dl_c_d[i];
      end
    end
  end

endmodule
